axi_full_slave_mem: RTL
=======================

# axi_full_slave_mem

AXI4 full-protocol slave with an internal word-addressed memory: the responder end for the `axi_full_master` burst initiator. It accepts INCR write bursts into the memory and serves INCR read bursts from it, on independent write and read channels. It drops into the master's example/BFM design as the DUT-side target for write-then-read-compare traffic.

## Interface
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID
- C_S_AXI_DATA_WIDTH, 32, data width (32 or 64)
- C_S_AXI_ADDR_WIDTH, 12, byte address width
- C_MEM_WORDS, 256, memory depth in data words (power of 2)

One clock; reset is synchronous and active-high.

- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous active-high reset
- S_AXI_AWID / S_AXI_AWADDR / S_AXI_AWLEN  in  ID / ADDR / 8  write burst ID, start byte address, beats-1
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1  AW handshake
- S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WLAST  in  DATA / DATA/8 / 1  write beat
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1  W handshake
- S_AXI_BID / S_AXI_BRESP  out  ID / 2  write response
- S_AXI_BVALID out 1 / S_AXI_BREADY in 1  B handshake
- S_AXI_ARID / S_AXI_ARADDR / S_AXI_ARLEN  in  ID / ADDR / 8  read burst ID, start byte address, beats-1
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1  AR handshake
- S_AXI_RID / S_AXI_RDATA / S_AXI_RRESP / S_AXI_RLAST  out  ID / DATA / 2 / 1  read beat
- S_AXI_RVALID out 1 / S_AXI_RREADY in 1  R handshake

SIZE/BURST/LOCK/CACHE/PROT/QOS are not ported. Every burst is INCR, full data width.

## Operation
- Word index = byte address >> log2(DATA/8), taken modulo C_MEM_WORDS. Unaligned low address bits are ignored. Addresses above the memory depth alias.
- Write FSM states:
  - W_IDLE: AWREADY=1. On AW handshake, latch ID, word index, and AWLEN into a beat counter; go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the bytes of the current word selected by WSTRB, then increments the index (wraps at C_MEM_WORDS-1 to 0). On the beat where count == AWLEN, go to W_RESP.
  - W_RESP: BVALID=1, BID = latched ID. Hold until BREADY, then go to W_IDLE.
- Burst end is set by the beat count, never by WLAST.
- BRESP = OKAY (2'b00) normally. BRESP = SLVERR (2'b10) if WLAST was 1 on any beat other than the last, or 0 on the last beat. The data is still written.
- Read FSM states:
  - R_IDLE: ARREADY=1. On AR handshake, latch ID, index, and ARLEN; go to R_DATA.
  - R_DATA: RVALID=1, RDATA = mem[index], RID = latched ID, RRESP = OKAY, RLAST=1 on beat ARLEN. On each R handshake, increment the index with wrap; after the RLAST handshake, go to R_IDLE.
- RDATA, RID and RLAST stay stable while RVALID=1 and RREADY=0.
- Write and read FSMs run concurrently with no ordering between them.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, BID=0, ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0. Ready outputs rise the cycle after ARESET deasserts.
- The memory array is not cleared by reset.
- AW handshake at cycle N: AWREADY=0 and WREADY=1 from N+1. A W beat is accepted every cycle while WVALID=1.
- Last W handshake at cycle M: BVALID=1 at M+1. BREADY seen at cycle K: AWREADY=1 at K+1.
- AR handshake at cycle N: first RVALID at N+1, then one beat per cycle under RREADY=1. RLAST handshake at cycle K: ARREADY=1 at K+1.
- Latency from AR handshake to last beat = ARLEN+1 cycles with no backpressure.
- A read and a write to the same word in the same cycle: the read returns the pre-write data. The write lands at the clock edge.
- AWLEN/ARLEN = 0 is a single beat. 255 gives 256 beats.
- Asserting ARESET mid-burst abandons the burst next edge: both FSMs go to IDLE and outputs take their reset values. Words already written remain.

## Test plan
- Single write then read:
  - Stimulus: AW addr 0x010, len 0, WDATA 0xDEADBEEF, WSTRB 0xF, WLAST 1; then AR 0x010.
  - Required: BRESP 0, RDATA 0xDEADBEEF, RLAST 1 on the first beat.
- 4-beat burst with strobes:
  - Stimulus: prefill 0x000–0x00C with 0xFFFFFFFF, then write 0x11111111..0x44444444 with beat-2 WSTRB 0x3.
  - Required: read back 0x11111111, 0x22222222, 0xFFFF3333, 0x44444444.
- Backpressure:
  - Stimulus: 8-beat read with RREADY toggling 1,0,0,1,...
  - Required: RDATA held during stalls, 8 beats delivered, RLAST only on beat 8, RID = ARID.
- Wraparound:
  - Stimulus: write 4 beats at byte 0x3F8 (C_MEM_WORDS=256).
  - Required: words 254, 255, 0, 1 written; read at 0x000 returns beat 3.
- WLAST error and concurrency:
  - Stimulus: 4-beat write with WLAST on beat 2, run concurrently with an 8-beat read elsewhere.
  - Required: 4 beats written, BRESP 2'b10, read data uncorrupted.
- Reset mid-burst:
  - Stimulus: assert ARESET after beat 2 of 8.
  - Required: BVALID/RVALID 0 next cycle, AWREADY/ARREADY 1 the cycle after release, beats 1–2 retained.

Source files
------------

// File: rtl/axi_full_slave_mem.sv
// AXI4 full slave with an internal word-addressed memory.
// INCR bursts only, with independent write and read channel FSMs.
module axi_full_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_MEM_WORDS        = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int NB = C_S_AXI_DATA_WIDTH / 8;
  localparam int SH = $clog2(NB);
  localparam int IW = $clog2(C_MEM_WORDS);

  typedef logic [C_S_AXI_ADDR_WIDTH-1:0] addr_t;
  typedef logic [C_S_AXI_DATA_WIDTH-1:0] data_t;
  typedef logic [C_S_AXI_ID_WIDTH-1:0]   id_t;
  typedef logic [IW-1:0]                 idx_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  // Low address bits below the word size are dropped; high bits alias.
  function automatic idx_t word_idx(input addr_t a);
    return IW'(a >> SH);
  endfunction

  data_t mem [C_MEM_WORDS];

  // Write channel state
  wstate_t    wst;
  logic       awready_q;
  logic       wready_q;
  logic       bvalid_q;
  logic [1:0] bresp_q;
  id_t        bid_q;
  id_t        wid_q;
  idx_t       widx;
  logic [7:0] wlen;
  logic [7:0] wcnt;
  logic       werr;

  logic wr_en;
  logic w_last;
  logic w_bad;

  assign wr_en  = wready_q && S_AXI_WVALID && !ARESET;
  assign w_last = (wcnt == wlen);
  assign w_bad  = (S_AXI_WLAST != w_last);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wst       <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      wid_q     <= '0;
      widx      <= '0;
      wlen      <= 8'd0;
      wcnt      <= 8'd0;
      werr      <= 1'b0;
    end else begin
      unique case (wst)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (S_AXI_AWVALID && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wid_q     <= S_AXI_AWID;
            widx      <= word_idx(S_AXI_AWADDR);
            wlen      <= S_AXI_AWLEN;
            wcnt      <= 8'd0;
            werr      <= 1'b0;
            wst       <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_en) begin
            widx <= widx + 1'b1;
            wcnt <= wcnt + 8'd1;
            if (w_bad) begin
              werr <= 1'b1;
            end
            // Beat count, not WLAST, closes the burst
            if (w_last) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr || w_bad) ? 2'b10 : 2'b00;
              bid_q    <= wid_q;
              wst      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wst       <= W_IDLE;
          end
        end
        default: wst <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b]) begin
          mem[widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  // Read channel state
  rstate_t    rst;
  logic       arready_q;
  logic       rvalid_q;
  logic       rlast_q;
  id_t        rid_q;
  data_t      rdata_q;
  idx_t       ridx;
  logic [7:0] rlen;
  logic [7:0] rcnt;

  idx_t       r_next_idx;
  logic [7:0] r_next_cnt;

  assign r_next_idx = ridx + 1'b1;
  assign r_next_cnt = rcnt + 8'd1;

  // RDATA is registered from the array, so a same-cycle write is not seen
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rst       <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      ridx      <= '0;
      rlen      <= 8'd0;
      rcnt      <= 8'd0;
    end else begin
      unique case (rst)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (S_AXI_ARVALID && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= S_AXI_ARID;
            ridx      <= word_idx(S_AXI_ARADDR);
            rdata_q   <= mem[word_idx(S_AXI_ARADDR)];
            rlen      <= S_AXI_ARLEN;
            rcnt      <= 8'd0;
            rlast_q   <= (S_AXI_ARLEN == 8'd0);
            rst       <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rst       <= R_IDLE;
            end else begin
              ridx    <= r_next_idx;
              rdata_q <= mem[r_next_idx];
              rcnt    <= r_next_cnt;
              rlast_q <= (r_next_cnt == rlen);
            end
          end
        end
        default: rst <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

endmodule
